// File: rtl/afu_mem_responder.sv
// afu_mem_responder -- memory-side responder for the AFU request/response
// interface. Sits opposite an afu_user instance and services cache-line
// reads and writes from a local RAM of 2^MEM_AW lines.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   rd_req_*              read request (addr, mdata, en) / almost-full back
//   rd_rsp_*              read response pulse (valid, mdata, data)
//   wr_req_*              write request (addr, mdata, data, en) / almost-full
//   wr_rsp0_*, wr_rsp1_*  write completions, alternating between channels
//   err_overflow          sticky: a request hit a full queue and was dropped
//
// Optional build macro AFU_MEM_RSP_DELAY_EN adds parameter RSP_DELAY and that
// many extra register stages on both response paths. Dispatch never stalls.

module afu_mem_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int AF_TH = 6
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         almostfull,
  output logic         ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_TH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          do_push, do_pop;

  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees a slot, so push at full is still accepted
  assign do_push = push && ((cnt != FULL_C) || do_pop);
  assign ovf     = push && !do_push;
  assign dout    = mem[rp];

  always_comb begin
    cnt_nxt = cnt;
    if (do_push) cnt_nxt = cnt_nxt + CW'(1);
    if (do_pop)  cnt_nxt = cnt_nxt - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      almostfull <= 1'b0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      cnt        <= cnt_nxt;
      almostfull <= (cnt_nxt >= AF_C);
    end

  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

module afu_mem_responder #(
  parameter int ADDR_LMT    = 20,
  parameter int MDATA       = 14,
  parameter int CACHE_WIDTH = 512,
  parameter int MEM_AW      = 6,
  parameter int FIFO_DEPTH  = 8,
  parameter int AF_MARGIN   = 2
`ifdef AFU_MEM_RSP_DELAY_EN
  , parameter int RSP_DELAY = 4
`endif
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [ADDR_LMT-1:0]    rd_req_addr,
  input  logic [MDATA-1:0]       rd_req_mdata,
  input  logic                   rd_req_en,
  output logic                   rd_req_almostfull,
  output logic                   rd_rsp_valid,
  output logic [MDATA-1:0]       rd_rsp_mdata,
  output logic [CACHE_WIDTH-1:0] rd_rsp_data,
  input  logic [ADDR_LMT-1:0]    wr_req_addr,
  input  logic [MDATA-1:0]       wr_req_mdata,
  input  logic [CACHE_WIDTH-1:0] wr_req_data,
  input  logic                   wr_req_en,
  output logic                   wr_req_almostfull,
  output logic                   wr_rsp0_valid,
  output logic [MDATA-1:0]       wr_rsp0_mdata,
  output logic                   wr_rsp1_valid,
  output logic [MDATA-1:0]       wr_rsp1_mdata,
  output logic                   err_overflow
);
`ifdef AFU_MEM_RSP_DELAY_EN
  localparam int STAGES = RSP_DELAY;
`else
  localparam int STAGES = 0;
`endif
  localparam int RW = MEM_AW + MDATA;
  localparam int WW = CACHE_WIDTH + MEM_AW + MDATA;

  logic [RW-1:0] rq_dout;
  logic [WW-1:0] wq_dout;
  logic          rq_empty, wq_empty, rq_ovf, wq_ovf;
  logic          sel_rd, sel_wr, prio_rd, wr_tog;

  // upper address bits are deliberately ignored (addresses wrap)
  logic unused_addr;
  assign unused_addr = ^{rd_req_addr, wr_req_addr};

  afu_mem_fifo #(.W(RW), .DEPTH(FIFO_DEPTH), .AF_TH(FIFO_DEPTH-AF_MARGIN)) u_rq (
    .clk(clk), .reset_n(reset_n), .push(rd_req_en),
    .din({rd_req_addr[MEM_AW-1:0], rd_req_mdata}), .pop(sel_rd),
    .dout(rq_dout), .empty(rq_empty), .almostfull(rd_req_almostfull), .ovf(rq_ovf));

  afu_mem_fifo #(.W(WW), .DEPTH(FIFO_DEPTH), .AF_TH(FIFO_DEPTH-AF_MARGIN)) u_wq (
    .clk(clk), .reset_n(reset_n), .push(wr_req_en),
    .din({wr_req_data, wr_req_addr[MEM_AW-1:0], wr_req_mdata}), .pop(sel_wr),
    .dout(wq_dout), .empty(wq_empty), .almostfull(wr_req_almostfull), .ovf(wq_ovf));

  // prio_rd names the queue that wins when both are pending; it always
  // points away from whichever queue was served last
  assign sel_rd = !rq_empty && (wq_empty || prio_rd);
  assign sel_wr = !wq_empty && !sel_rd;

  logic [CACHE_WIDTH-1:0] ram [2**MEM_AW];
  logic [STAGES:0]        rd_vld_pipe, wr_vld_pipe;
  logic [MDATA-1:0]       rd_md_pipe [STAGES:0];
  logic [MDATA-1:0]       wr_md_pipe [STAGES:0];
  logic [CACHE_WIDTH-1:0] rd_d_pipe  [STAGES:0];

  // RAM and payload stages carry no reset; outputs are gated by the
  // reset-cleared valid pipes instead
  always_ff @(posedge clk) begin
    if (sel_wr) ram[wq_dout[MDATA +: MEM_AW]] <= wq_dout[WW-1 -: CACHE_WIDTH];
    rd_d_pipe[0]  <= ram[rq_dout[MDATA +: MEM_AW]];
    rd_md_pipe[0] <= rq_dout[MDATA-1:0];
    wr_md_pipe[0] <= wq_dout[MDATA-1:0];
    for (int i = 1; i <= STAGES; i++) begin
      rd_d_pipe[i]  <= rd_d_pipe[i-1];
      rd_md_pipe[i] <= rd_md_pipe[i-1];
      wr_md_pipe[i] <= wr_md_pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_vld_pipe  <= '0;
      wr_vld_pipe  <= '0;
      prio_rd      <= 1'b1;
      wr_tog       <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      rd_vld_pipe[0] <= sel_rd;
      wr_vld_pipe[0] <= sel_wr;
      for (int i = 1; i <= STAGES; i++) begin
        rd_vld_pipe[i] <= rd_vld_pipe[i-1];
        wr_vld_pipe[i] <= wr_vld_pipe[i-1];
      end
      if (sel_rd) prio_rd <= 1'b0;
      else if (sel_wr) prio_rd <= 1'b1;
      // channel toggles on emitted completions, so flushed ones never count
      if (wr_vld_pipe[STAGES]) wr_tog <= ~wr_tog;
      if (rq_ovf || wq_ovf) err_overflow <= 1'b1;
    end

  assign rd_rsp_valid  = rd_vld_pipe[STAGES];
  assign rd_rsp_mdata  = rd_rsp_valid ? rd_md_pipe[STAGES] : '0;
  assign rd_rsp_data   = rd_rsp_valid ? rd_d_pipe[STAGES]  : '0;
  assign wr_rsp0_valid = wr_vld_pipe[STAGES] && !wr_tog;
  assign wr_rsp1_valid = wr_vld_pipe[STAGES] &&  wr_tog;
  assign wr_rsp0_mdata = wr_rsp0_valid ? wr_md_pipe[STAGES] : '0;
  assign wr_rsp1_mdata = wr_rsp1_valid ? wr_md_pipe[STAGES] : '0;
endmodule

// File: tb/tb_afu_mem_responder.sv
// Bench for afu_mem_responder: randomized and directed traffic checked every
// cycle against a transaction-level model (request queues, RAM array and
// time-stamped response queues).
module tb_afu_mem_responder;
`ifdef AFU_MEM_RSP_DELAY_EN
  localparam int DLY = 4;
`else
  localparam int DLY = 0;
`endif
  localparam int DEPTH = 8;
  localparam int AF_TH = 6;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [19:0]  rd_req_addr, wr_req_addr;
  logic [13:0]  rd_req_mdata, wr_req_mdata;
  logic         rd_req_en, wr_req_en;
  logic [511:0] wr_req_data;
  logic         rd_req_almostfull, wr_req_almostfull;
  logic         rd_rsp_valid, wr_rsp0_valid, wr_rsp1_valid, err_overflow;
  logic [13:0]  rd_rsp_mdata, wr_rsp0_mdata, wr_rsp1_mdata;
  logic [511:0] rd_rsp_data;

  afu_mem_responder dut (
    .clk(clk), .reset_n(reset_n),
    .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata), .rd_req_en(rd_req_en),
    .rd_req_almostfull(rd_req_almostfull),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_mdata(rd_rsp_mdata), .rd_rsp_data(rd_rsp_data),
    .wr_req_addr(wr_req_addr), .wr_req_mdata(wr_req_mdata), .wr_req_data(wr_req_data),
    .wr_req_en(wr_req_en), .wr_req_almostfull(wr_req_almostfull),
    .wr_rsp0_valid(wr_rsp0_valid), .wr_rsp0_mdata(wr_rsp0_mdata),
    .wr_rsp1_valid(wr_rsp1_valid), .wr_rsp1_mdata(wr_rsp1_mdata),
    .err_overflow(err_overflow));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int a; logic [13:0] md; logic [511:0] d; } req_t;
  typedef struct { longint due; logic [13:0] md; logic [511:0] d; } rsp_t;
  req_t         mrq[$], mwq[$];
  rsp_t         rdq[$], wrq[$];
  logic [511:0] mmem [64];
  bit           mprio_rd, mtog, merr;
  longint       cyc = 0;

  task automatic model_reset();
    mrq.delete(); mwq.delete(); rdq.delete(); wrq.delete();
    mprio_rd = 1; mtog = 0; merr = 0;
  endtask

  // what the upcoming clock edge does: one dispatch, then enqueue
  task automatic model_step();
    req_t r; rsp_t s; bit rne, wne;
    rne = mrq.size() > 0;
    wne = mwq.size() > 0;
    if (rne && (!wne || mprio_rd)) begin
      r = mrq.pop_front();
      s.due = cyc + 1 + DLY; s.md = r.md; s.d = mmem[r.a];
      rdq.push_back(s);
      mprio_rd = 0;
    end else if (wne) begin
      r = mwq.pop_front();
      mmem[r.a] = r.d;
      s.due = cyc + 1 + DLY; s.md = r.md; s.d = '0;
      wrq.push_back(s);
      mprio_rd = 1;
    end
    if (rd_req_en) begin
      if (mrq.size() < DEPTH) begin
        r.a = int'(rd_req_addr) % 64; r.md = rd_req_mdata; r.d = '0;
        mrq.push_back(r);
      end else merr = 1;
    end
    if (wr_req_en) begin
      if (mwq.size() < DEPTH) begin
        r.a = int'(wr_req_addr) % 64; r.md = wr_req_mdata; r.d = wr_req_data;
        mwq.push_back(r);
      end else merr = 1;
    end
  endtask

  task automatic compare();
    rsp_t s; bit ev;
    ev = (rdq.size() > 0) && (rdq[0].due == cyc);
    chk("rd_vld", rd_rsp_valid, ev);
    if (ev) begin
      s = rdq.pop_front();
      chk("rd_mdata", rd_rsp_mdata, s.md);
      chk("rd_data", rd_rsp_data, s.d);
    end
    ev = (wrq.size() > 0) && (wrq[0].due == cyc);
    chk("wr0_vld", wr_rsp0_valid, ev && !mtog);
    chk("wr1_vld", wr_rsp1_valid, ev && mtog);
    if (ev) begin
      s = wrq.pop_front();
      if (mtog) chk("wr1_mdata", wr_rsp1_mdata, s.md);
      else      chk("wr0_mdata", wr_rsp0_mdata, s.md);
      mtog = !mtog;
    end
    chk("rd_af", rd_req_almostfull, mrq.size() >= AF_TH);
    chk("wr_af", wr_req_almostfull, mwq.size() >= AF_TH);
    chk("err_ovf", err_overflow, merr);
  endtask

  // called at a falling edge; returns at the next falling edge
  task automatic cycle(input bit re, input logic [19:0] ra, input logic [13:0] rm,
                       input bit we, input logic [19:0] wa, input logic [13:0] wm,
                       input logic [511:0] wd);
    rd_req_en = re; rd_req_addr = ra; rd_req_mdata = rm;
    wr_req_en = we; wr_req_addr = wa; wr_req_mdata = wm; wr_req_data = wd;
    model_step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, '0, '0, '0);
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_vld"}, rd_rsp_valid, 0);
    chk({tag, "_rd_md"}, rd_rsp_mdata, 0);
    chk({tag, "_rd_data"}, rd_rsp_data, 0);
    chk({tag, "_wr0"}, {wr_rsp0_valid, wr_rsp0_mdata}, 0);
    chk({tag, "_wr1"}, {wr_rsp1_valid, wr_rsp1_mdata}, 0);
    chk({tag, "_af"}, {rd_req_almostfull, wr_req_almostfull}, 0);
    chk({tag, "_err"}, err_overflow, 0);
  endtask

  task automatic rand_traffic(input int n, input int pr, input int pw);
    for (int i = 0; i < n; i++)
      cycle($urandom_range(99) < pr, 20'($urandom), 14'($urandom),
            $urandom_range(99) < pw, 20'($urandom), 14'($urandom), rand512());
  endtask

  logic [511:0] pat_a5, pat_w;

  initial begin
    reset_n = 0;
    rd_req_en = 0; rd_req_addr = '0; rd_req_mdata = '0;
    wr_req_en = 0; wr_req_addr = '0; wr_req_mdata = '0; wr_req_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_all_zero("rst");
    @(negedge clk);
    reset_n = 1;

    // give every RAM line a known value
    for (int i = 0; i < 64; i++) cycle(0, '0, '0, 1, 20'(i), 14'(i), rand512());
    idle(3 + DLY);

    // write then read the same line
    for (int i = 0; i < 64; i++) pat_a5[i*8 +: 8] = 8'hA5;
    cycle(0, '0, '0, 1, 20'd5, 14'd3, pat_a5);
    idle(3 + DLY);
    cycle(1, 20'd5, 14'd7, 0, '0, '0, '0);
    idle(3 + DLY);

    // back-to-back writes alternate completion channels
    for (int i = 0; i < 4; i++) cycle(0, '0, '0, 1, 20'(40 + i), 14'(i), rand512());
    idle(4 + DLY);

    // both queues loaded together: read of line 2 races the write of 0x1234
    for (int i = 0; i < 4; i++)
      cycle(1, (i == 0) ? 20'd2 : 20'(10 + i), 14'(20 + i),
            1, (i == 0) ? 20'd2 : 20'(30 + i), 14'(50 + i),
            (i == 0) ? 512'h1234 : rand512());
    cycle(1, 20'd2, 14'd99, 0, '0, '0, '0);
    idle(10 + DLY);

    // address wrap: line 0x40 aliases line 0
    pat_w = rand512();
    cycle(0, '0, '0, 1, 20'h00040, 14'd11, pat_w);
    idle(2);
    cycle(1, 20'd0, 14'd12, 0, '0, '0, '0);
    idle(3 + DLY);

    rand_traffic(300, 40, 40);
    idle(20 + DLY);

    // flood both queues: almost-full rises, then requests are dropped
    rand_traffic(24, 100, 100);
    idle(20 + DLY);

    // mid-operation reset with requests still queued
    rand_traffic(6, 100, 100);
    #2 reset_n = 0;
    #1 chk_all_zero("midrst");
    model_reset();
    rd_req_en = 0; wr_req_en = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    idle(12 + DLY);

    rand_traffic(200, 45, 45);
    idle(20 + DLY);
    chk("rd_drained", rdq.size() == 0 && rd_rsp_valid == 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
